medac_cal_seq: RTL and testbench

//  Calibration sequencer for the MEDAC delay line. Sweeps the origin delay code

---
 rtl/medac_cal_seq.sv | 185 ++++++++++++++++++
 tb/tb_medac_cal_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/medac_cal_seq.sv
// medac_cal_seq: calibration sequencer for the MEDAC origin delay line.
// Sweeps every delay code, counts errors over a fixed window per code after a
// settle interval, keeps the lowest-error code (lowest code wins ties) and
// commits it to the delay line when the sweep completes.
module medac_cal_seq #(
   parameter int SEL_W      = 4,
   parameter int SETTLE_CYC = 16,
   parameter int WIN_CYC    = 1024,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cal_req,
   input  logic             cal_abort,
   input  logic             error_in,
   output logic [SEL_W-1:0] sel_out,
   output logic             meas_start,
   output logic             cal_busy,
   output logic             cal_done,
   output logic [SEL_W-1:0] best_sel,
   output logic [CNT_W-1:0] best_err
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETTLE  = 3'd1;
   localparam logic [2:0] ST_MEASURE = 3'd2;
   localparam logic [2:0] ST_COMPARE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // One shared interval timer serves both SETTLE and MEASURE.
   localparam int TMR_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_ONE     = {{(TMR_W-1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0] CODE_LAST   = {SEL_W{1'b1}};
   localparam logic [SEL_W-1:0] CODE_ONE    = {{(SEL_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ERR_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ERR_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [SEL_W-1:0] code_q, code_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [SEL_W-1:0] run_sel_q, run_sel_d;
   logic [CNT_W-1:0] run_err_q, run_err_d;
   logic [SEL_W-1:0] commit_q, commit_d;

   logic [SEL_W-1:0] sel_q;
   logic             meas_q;
   logic             busy_q;
   logic             done_q;
   logic [SEL_W-1:0] best_sel_q;
   logic [CNT_W-1:0] best_err_q;

   // Next-state logic for the sweep FSM, its timer, error counter and running best.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      code_d    = code_q;
      err_d     = err_q;
      run_sel_d = run_sel_q;
      run_err_d = run_err_q;
      commit_d  = commit_q;
      if (cal_abort) begin
         // Abort wins everywhere; committed code and results stay untouched.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cal_req) begin
                  state_d   = ST_SETTLE;
                  tmr_d     = {TMR_W{1'b0}};
                  code_d    = {SEL_W{1'b0}};
                  run_sel_d = {SEL_W{1'b0}};
                  run_err_d = ERR_MAX;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (tmr_q == SETTLE_LAST) begin
                  state_d = ST_MEASURE;
                  tmr_d   = {TMR_W{1'b0}};
                  err_d   = {CNT_W{1'b0}};
               end else begin
                  tmr_d = tmr_q + TMR_ONE;
               end
            end
            ST_MEASURE: begin
               // Saturating count so a noisy code can never wrap to look clean.
               if (error_in && (err_q != ERR_MAX)) begin
                  err_d = err_q + ERR_ONE;
               end else begin
                  err_d = err_q;
               end
               if (tmr_q == WIN_LAST) begin
                  state_d = ST_COMPARE;
                  tmr_d   = {TMR_W{1'b0}};
               end else begin
                  tmr_d = tmr_q + TMR_ONE;
               end
            end
            ST_COMPARE: begin
               // Strict less-than: on a tie the earlier (lower) code is kept.
               if (err_q < run_err_q) begin
                  run_err_d = err_q;
                  run_sel_d = code_q;
               end else begin
                  run_err_d = run_err_q;
                  run_sel_d = run_sel_q;
               end
               if (code_q == CODE_LAST) begin
                  state_d  = ST_DONE;
                  commit_d = run_sel_d;
               end else begin
                  state_d = ST_SETTLE;
                  code_d  = code_q + CODE_ONE;
                  tmr_d   = {TMR_W{1'b0}};
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tmr_q     <= {TMR_W{1'b0}};
         code_q    <= {SEL_W{1'b0}};
         err_q     <= {CNT_W{1'b0}};
         run_sel_q <= {SEL_W{1'b0}};
         run_err_q <= {CNT_W{1'b0}};
         commit_q  <= {SEL_W{1'b0}};
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         code_q    <= code_d;
         err_q     <= err_d;
         run_sel_q <= run_sel_d;
         run_err_q <= run_err_d;
         commit_q  <= commit_d;
      end
   end

   // Output registers, decoded from next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q      <= {SEL_W{1'b0}};
         meas_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         best_sel_q <= {SEL_W{1'b0}};
         best_err_q <= {CNT_W{1'b0}};
      end else begin
         sel_q  <= ((state_d == ST_IDLE) || (state_d == ST_DONE)) ? commit_d : code_d;
         meas_q <= (state_d == ST_MEASURE);
         busy_q <= (state_d != ST_IDLE);
         done_q <= (state_d == ST_DONE);
         if (state_d == ST_DONE) begin
            best_sel_q <= run_sel_d;
            best_err_q <= run_err_d;
         end else begin
            best_sel_q <= best_sel_q;
            best_err_q <= best_err_q;
         end
      end
   end

   assign sel_out    = sel_q;
   assign meas_start = meas_q;
   assign cal_busy   = busy_q;
   assign cal_done   = done_q;
   assign best_sel   = best_sel_q;
   assign best_err   = best_err_q;

endmodule

// File: tb/tb_medac_cal_seq.sv
// tb_medac_cal_seq: directed bench for medac_cal_seq with SETTLE_CYC=2,
// WIN_CYC=8. A 16-bit-counter instance and a 3-bit (saturating) instance share
// the stimulus. Full sweeps are table-driven; reset, abort and request corner
// cases are hand-written sequences.
module tb_medac_cal_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cal_req;
   logic        cal_abort;
   logic        error_in;

   logic [3:0]  sel_out, best_sel;
   logic        meas_start, cal_busy, cal_done;
   logic [15:0] best_err;

   logic [3:0]  s_sel_out, s_best_sel;
   logic        s_meas_start, s_cal_busy, s_cal_done;
   logic [2:0]  s_best_err;

   int n_vec = 0;
   int n_err = 0;

   medac_cal_seq #(.SEL_W(4), .SETTLE_CYC(2), .WIN_CYC(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .cal_req(cal_req), .cal_abort(cal_abort),
      .error_in(error_in), .sel_out(sel_out), .meas_start(meas_start),
      .cal_busy(cal_busy), .cal_done(cal_done), .best_sel(best_sel),
      .best_err(best_err)
   );

   medac_cal_seq #(.SEL_W(4), .SETTLE_CYC(2), .WIN_CYC(8), .CNT_W(3)) u_sat (
      .clk(clk), .rst_n(rst_n), .cal_req(cal_req), .cal_abort(cal_abort),
      .error_in(error_in), .sel_out(s_sel_out), .meas_start(s_meas_start),
      .cal_busy(s_cal_busy), .cal_done(s_cal_done), .best_sel(s_best_sel),
      .best_err(s_best_err)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      int          mode;       // error_in pattern, see err_for
      int          pulse_at;   // cycle of a stray cal_req while busy (0 = none)
      logic [3:0]  exp_sel;
      logic [15:0] exp_err;
      logic [3:0]  exp_sat_sel;
      logic [2:0]  exp_sat_err;
   } sweep_vec_t;

   sweep_vec_t vecs [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // mode 0: errors except on code 5; 1: always; 2: only codes 0..2; 3: never
   function automatic logic err_for(input int mode, input logic [3:0] sel);
      case (mode)
         0: return (sel != 4'd5);
         1: return 1'b1;
         2: return (sel < 4'd3);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] all_out();
      return 64'({sel_out, meas_start, cal_busy, cal_done, best_sel, best_err,
                  s_sel_out, s_meas_start, s_cal_busy, s_cal_done, s_best_sel, s_best_err});
   endfunction

   initial begin
      logic [3:0]  prev_sel;
      logic [15:0] prev_err;
      int          n;
      int          meas_cnt;
      int          bad;
      int          done_cnt;
      logic        done_seen;

      vecs[0] = '{mode: 2, pulse_at: 0,  exp_sel: 4'd3, exp_err: 16'd0, exp_sat_sel: 4'd3, exp_sat_err: 3'd0};
      vecs[1] = '{mode: 1, pulse_at: 0,  exp_sel: 4'd0, exp_err: 16'd8, exp_sat_sel: 4'd0, exp_sat_err: 3'd7};
      vecs[2] = '{mode: 0, pulse_at: 50, exp_sel: 4'd5, exp_err: 16'd0, exp_sat_sel: 4'd5, exp_sat_err: 3'd0};
      vecs[3] = '{mode: 0, pulse_at: 0,  exp_sel: 4'd5, exp_err: 16'd0, exp_sat_sel: 4'd5, exp_sat_err: 3'd0};

      // Reset held while inputs toggle: every output stays 0
      rst_n = 1'b0; cal_req = 1'b0; cal_abort = 1'b0; error_in = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cal_req   = 1'($urandom_range(1, 0));
         cal_abort = 1'($urandom_range(1, 0));
         error_in  = 1'($urandom_range(1, 0));
         if (all_out() != 64'd0) bad++;
      end
      chk("reset_outputs", 64'(bad), 64'd0);

      @(negedge clk);
      cal_req = 1'b0; cal_abort = 1'b0; error_in = 1'b0;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (all_out() != 64'd0) bad++;
      end
      chk("idle_after_reset", 64'(bad), 64'd0);

      prev_sel = 4'd0;
      prev_err = 16'd0;

      // Table-driven full sweeps
      for (int v = 0; v < 4; v++) begin
         cal_req = 1'b1;
         @(negedge clk);            // edge k sampled the request; this is cycle k+1
         cal_req = 1'b0;
         chk("busy_at_k1", 64'(cal_busy), 64'd1);
         n = 1; meas_cnt = 0; done_seen = 1'b0;
         while (!done_seen && n < 400) begin
            error_in = err_for(vecs[v].mode, sel_out);
            cal_req  = (n == vecs[v].pulse_at) && (vecs[v].pulse_at != 0);
            if (meas_start) meas_cnt++;
            if (n == 100) begin
               chk("best_sel_hold", 64'(best_sel), 64'(prev_sel));
               chk("best_err_hold", 64'(best_err), 64'(prev_err));
            end
            if (cal_done) begin
               done_seen = 1'b1;
            end else begin
               n++;
               @(negedge clk);
            end
         end
         cal_req = 1'b0;
         chk("done_seen", 64'(done_seen), 64'd1);
         chk("done_latency", 64'(n), 64'd177);
         chk("meas_cycles", 64'(meas_cnt), 64'd128);
         chk("best_sel", 64'(best_sel), 64'(vecs[v].exp_sel));
         chk("best_err", 64'(best_err), 64'(vecs[v].exp_err));
         chk("sat_best_sel", 64'(s_best_sel), 64'(vecs[v].exp_sat_sel));
         chk("sat_best_err", 64'(s_best_err), 64'(vecs[v].exp_sat_err));
         error_in = 1'b0;
         @(negedge clk);
         chk("sel_after_done", 64'(sel_out), 64'(vecs[v].exp_sel));
         chk("idle_after_done", 64'({cal_busy, cal_done, meas_start}), 64'd0);
         prev_sel = vecs[v].exp_sel;
         prev_err = vecs[v].exp_err;
      end

      // Abort while code 9 is applied: back to committed code 5, no cal_done
      cal_req = 1'b1;
      @(negedge clk);
      cal_req = 1'b0;
      n = 0;
      while (sel_out != 4'd9 && n < 300) begin
         error_in = 1'b1;
         n++;
         @(negedge clk);
      end
      chk("reached_code9", 64'(sel_out), 64'd9);
      cal_abort = 1'b1;
      @(negedge clk);
      cal_abort = 1'b0;
      error_in  = 1'b0;
      chk("abort_busy", 64'(cal_busy), 64'd0);
      chk("abort_sel", 64'(sel_out), 64'd5);
      chk("abort_best", 64'({best_sel, best_err}), 64'({4'd5, 16'd0}));
      done_cnt = 0;
      if (cal_done) done_cnt++;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cal_done || cal_busy) done_cnt++;
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);

      // cal_req together with cal_abort in IDLE: stays IDLE
      cal_req = 1'b1; cal_abort = 1'b1;
      @(negedge clk);
      cal_req = 1'b0; cal_abort = 1'b0;
      chk("req_abort_idle", 64'(cal_busy), 64'd0);
      @(negedge clk);
      chk("req_abort_still_idle", 64'({cal_busy, sel_out}), 64'({1'b0, 4'd5}));

      // Asynchronous reset in the middle of a sweep
      cal_req = 1'b1;
      @(negedge clk);
      cal_req = 1'b0;
      for (int i = 0; i < 30; i++) @(negedge clk);
      chk("mid_sweep_busy", 64'(cal_busy), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", all_out(), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_commit", 64'({sel_out, cal_busy}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
